// File: rtl/mcu_pkg.sv
// mcu_pkg: shared types and constants for the RC4-decrypt + Sobel control unit.
//   - mcu_state_t   : controller FSM state encoding
//   - ADDR_W_DEF    : default byte address width of image memory
//   - DIM_W_DEF     : default width of image_width / image_height
//   - MIN_DIM       : smallest width/height the Sobel pass can work on
//   - is_wait_state : states in which the optional watchdog (MCU_TIMEOUT_EN) counts
package mcu_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DIM_W_DEF  = 12;
   localparam int MIN_DIM    = 3;

   typedef enum logic [3:0] {
      IDLE,
      KEY_INIT,
      KEY_WAIT,
      RD,
      KS,
      WR,
      SOB_START,
      SOB_WAIT,
      DONE,
      ERR
   } mcu_state_t;

   // States that sit waiting on an external agent.
   function automatic logic is_wait_state(input mcu_state_t s);
      return (s == KEY_WAIT) || (s == RD) || (s == KS) ||
             (s == WR) || (s == SOB_WAIT);
   endfunction

endpackage

// File: rtl/mcu_addr_gen.sv
// mcu_addr_gen: pixel index / Sobel row counters and the two byte-address adders.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   idx_clr, idx_inc  : clear / advance the pixel index (clear wins)
//   row_init, row_inc : load row=1 / advance the Sobel row (init wins)
//   src, dec_base     : encrypted-image base and decrypted-buffer base
//   idx, row          : current counter values
//   rd_addr, wr_addr  : src+idx and dec_base+idx, wrapping modulo 2^ADDR_W
module mcu_addr_gen
   import mcu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = DIM_W_DEF,
   parameter int CNT_W  = 2 * DIM_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              idx_clr,
   input  logic              idx_inc,
   input  logic              row_init,
   input  logic              row_inc,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dec_base,
   output logic [CNT_W-1:0]  idx,
   output logic [DIM_W-1:0]  row,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr
);

   logic [CNT_W-1:0] idx_q, idx_d;
   logic [DIM_W-1:0] row_q, row_d;

   always_comb begin
      idx_d = idx_q;
      if (idx_clr) begin
         idx_d = '0;
      end else if (idx_inc) begin
         idx_d = idx_q + CNT_W'(1);
      end
      row_d = row_q;
      if (row_init) begin
         row_d = DIM_W'(1);
      end else if (row_inc) begin
         row_d = row_q + DIM_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         row_q <= '0;
      end else begin
         idx_q <= idx_d;
         row_q <= row_d;
      end
   end

   assign idx     = idx_q;
   assign row     = row_q;
   // Truncating the index is the intended modulo-2^ADDR_W wrap.
   assign rd_addr = src + ADDR_W'(idx_q);
   assign wr_addr = dec_base + ADDR_W'(idx_q);

endmodule

// File: rtl/mcu_controller.sv
// mcu_controller: control unit for the RC4-decrypt + Sobel pipeline.
// Pass 1 reads each encrypted byte, XORs it with one RC4 keystream byte and
// writes the plaintext into a buffer placed right after the source image.
// Pass 2 starts the Sobel engine once per interior row.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   start, image_*                  : job request and image configuration
//   process_complete, error, busy   : status back to the AHB slave
//   rc4_key/rc4_key_out, rc4_init,
//   rc4_ready, ks_*                 : RC4 core interface
//   mem_*                           : byte memory port
//   sobel_*                         : Sobel engine interface
//   dbg_state                       : current FSM state, for observation only
// Handshakes: every request (mem_req, ks_req) is a level held with stable
// address/data until its completion (mem_ack/mem_error, ks_valid); a
// completion in the very cycle the request first rises is accepted.
// Optional: define MCU_TIMEOUT_EN to add a watchdog that aborts to ERR after
// TIMEOUT_CYC cycles spent in one waiting state.
module mcu_controller
   import mcu_pkg::*;
#(
   parameter int          ADDR_W      = ADDR_W_DEF,
   parameter int          DIM_W       = DIM_W_DEF,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       rc4_key,
   input  logic [DIM_W-1:0]  image_width,
   input  logic [DIM_W-1:0]  image_height,
   input  logic [ADDR_W-1:0] image_startAddr,
   output logic              process_complete,
   output logic              error,
   output logic              busy,
   output logic              rc4_init,
   output logic [31:0]       rc4_key_out,
   input  logic              rc4_ready,
   output logic              ks_req,
   input  logic              ks_valid,
   input  logic [7:0]        ks_byte,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_error,
   output logic              sobel_start,
   output logic [DIM_W-1:0]  sobel_row,
   output logic [ADDR_W-1:0] sobel_base,
   input  logic              sobel_done,
   output mcu_state_t        dbg_state
);

   localparam int CNT_W = 2 * DIM_W;

   mcu_state_t        state_q, state_d;
   logic [DIM_W-1:0]  h_q, h_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dec_base_q, dec_base_d;
   logic [7:0]        rdata_q, rdata_d;
   logic [7:0]        ks_q, ks_d;

   logic              idx_clr, idx_inc, row_init, row_inc;
   logic [CNT_W-1:0]  idx;
   logic [DIM_W-1:0]  row;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [CNT_W-1:0]  area;

   assign area = CNT_W'(image_width) * CNT_W'(image_height);

   mcu_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W),
      .CNT_W  (CNT_W)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .idx_clr  (idx_clr),
      .idx_inc  (idx_inc),
      .row_init (row_init),
      .row_inc  (row_inc),
      .src      (src_q),
      .dec_base (dec_base_q),
      .idx      (idx),
      .row      (row),
      .rd_addr  (rd_addr),
      .wr_addr  (wr_addr)
   );

`ifdef MCU_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;
   logic        wd_fire;

   // Fires in the cycle the count reaches TIMEOUT_CYC-1, so ERR is entered
   // exactly TIMEOUT_CYC cycles after the waiting state was entered.
   assign wd_fire = is_wait_state(state_q) && (wd_q == TIMEOUT_CYC - 1);

   always_comb begin
      wd_d = '0;
      if ((state_d == state_q) && is_wait_state(state_q)) begin
         wd_d = wd_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`endif

   // Next-state and datapath register updates.
   always_comb begin
      state_d    = state_q;
      h_d        = h_q;
      count_d    = count_q;
      src_d      = src_q;
      dec_base_d = dec_base_q;
      rdata_d    = rdata_q;
      ks_d       = ks_q;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      row_init   = 1'b0;
      row_inc    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               h_d        = image_height;
               count_d    = area;
               src_d      = image_startAddr;
               dec_base_d = image_startAddr + ADDR_W'(area);
               idx_clr    = 1'b1;
               if ((image_width < DIM_W'(MIN_DIM)) || (image_height < DIM_W'(MIN_DIM))) begin
                  state_d = ERR;
               end else begin
                  state_d = KEY_INIT;
               end
            end
         end
         KEY_INIT: state_d = KEY_WAIT;
         KEY_WAIT: begin
            if (rc4_ready) begin
               idx_clr = 1'b1;
               state_d = RD;
            end
         end
         RD: begin
            // A simultaneous error beats the ack.
            if (mem_error) begin
               state_d = ERR;
            end else if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = KS;
            end
         end
         KS: begin
            if (ks_valid) begin
               ks_d    = ks_byte;
               state_d = WR;
            end
         end
         WR: begin
            if (mem_error) begin
               state_d = ERR;
            end else if (mem_ack) begin
               idx_inc = 1'b1;
               if ((idx + CNT_W'(1)) == count_q) begin
                  row_init = 1'b1;
                  state_d  = SOB_START;
               end else begin
                  state_d = RD;
               end
            end
         end
         SOB_START: state_d = SOB_WAIT;
         SOB_WAIT: begin
            if (sobel_done) begin
               row_inc = 1'b1;
               // Interior rows are 1 .. H-2.
               if ((row + DIM_W'(1)) == (h_q - DIM_W'(1))) begin
                  state_d = DONE;
               end else begin
                  state_d = SOB_START;
               end
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef MCU_TIMEOUT_EN
      if (wd_fire) begin
         state_d = ERR;
      end
`endif
   end

   // Outputs are pure functions of the state register, so reset clears them.
   always_comb begin
      busy             = (state_q != IDLE);
      rc4_init         = (state_q == KEY_INIT);
      ks_req           = (state_q == KS);
      mem_req          = (state_q == RD) || (state_q == WR);
      mem_write        = (state_q == WR);
      mem_addr         = '0;
      mem_wdata        = '0;
      sobel_start      = (state_q == SOB_START);
      sobel_row        = '0;
      sobel_base       = '0;
      process_complete = (state_q == DONE);
      error            = (state_q == ERR);
      if (state_q == RD) begin
         mem_addr = rd_addr;
      end else if (state_q == WR) begin
         mem_addr  = wr_addr;
         mem_wdata = rdata_q ^ ks_q;
      end
      if (state_q == SOB_START) begin
         sobel_row  = row;
         sobel_base = dec_base_q;
      end
   end

   assign rc4_key_out = rc4_key;
   assign dbg_state   = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         h_q        <= '0;
         count_q    <= '0;
         src_q      <= '0;
         dec_base_q <= '0;
         rdata_q    <= '0;
         ks_q       <= '0;
      end else begin
         state_q    <= state_d;
         h_q        <= h_d;
         count_q    <= count_d;
         src_q      <= src_d;
         dec_base_q <= dec_base_d;
         rdata_q    <= rdata_d;
         ks_q       <= ks_d;
      end
   end

endmodule
